// File: rtl/spi_frame_rx_pkg.sv
// Shared types and constants for the SPI configuration-frame receiver.
//   spi_state_e  : receiver FSM states
//   synth_t      : packed image of the synth core configuration
//   status_byte  : first byte returned on MISO in every transaction
package spi_frame_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        OVERRUN = 2'd2
    } spi_state_e;

    // Synth core configuration image (64 bytes).
    typedef struct packed {
        logic [15:0][15:0] osc_pitch;
        logic [15:0][7:0]  osc_level;
        logic [7:0][7:0]   env_rate;
        logic [7:0][7:0]   filt_cfg;
    } synth_t;

    localparam int unsigned SYNTH_FRAME_BYTES = $bits(synth_t) / 8;

    // Status byte: {err_long, err_short, frame_count[5:0]}.
    function automatic logic [7:0] status_byte(input logic       err_long,
                                               input logic       err_short,
                                               input logic [5:0] count);
        return {err_long, err_short, count};
    endfunction

endpackage

// File: rtl/spi_frame_rx_if.sv
// SPI pins plus the committed-frame/status bus of spi_frame_rx.
//   slave  : receiver side (samples SPI pins, drives frame/status/miso)
//   master : host / consumer side
interface spi_frame_rx_if
    import spi_frame_rx_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = SYNTH_FRAME_BYTES
);
    logic                     sclk;
    logic                     mosi;
    logic                     csel;
    logic                     miso;
    logic [FRAME_BYTES*8-1:0] frame;
    logic                     frame_valid;
    logic [7:0]               frame_count;
    logic                     err_short;
    logic                     err_long;
    logic                     err_clr;

    modport slave (
        input  sclk, mosi, csel, err_clr,
        output miso, frame, frame_valid, frame_count, err_short, err_long
    );

    modport master (
        output sclk, mosi, csel, err_clr,
        input  miso, frame, frame_valid, frame_count, err_short, err_long
    );
endinterface

// File: rtl/spi_frame_rx_sync_edge.sv
// Multi-stage synchroniser with rise/fall strobes for one asynchronous pin.
//   clk, rst : system clock, async active-high reset
//   d        : asynchronous input pin
//   rise_c   : one-clk strobe, synchronised rising edge
//   fall_c   : one-clk strobe, synchronised falling edge
// Strobes stay masked after reset until the pipeline holds real samples and
// the pin has been seen at its idle level, so a pin parked non-idle across
// reset does not look like a fresh edge.
module spi_frame_rx_sync_edge
    import spi_frame_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic [SYNC_STAGES:0]   prime_q, prime_d;
    logic                   armed_q, armed_d;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    // Next-state for synchroniser, delay flop and arming.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], d};
        dly_d   = level;
        prime_d = {prime_q[SYNC_STAGES-1:0], 1'b1};
        armed_d = armed_q | (prime_q[SYNC_STAGES] & (level == IDLE_VAL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{IDLE_VAL}};
            dly_q   <= IDLE_VAL;
            prime_q <= '0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            dly_q   <= dly_d;
            prime_q <= prime_d;
            armed_q <= armed_d;
        end
    end

    assign rise_c = armed_q &  level & ~dly_q;
    assign fall_c = armed_q & ~level &  dly_q;
endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave receiving one fixed-length frame per chip-select assertion and
// committing it atomically to a wide register.
//   clk, rst : system clock (>= 8x sclk), async active-high reset
//   bus      : slave modport: sclk/mosi/csel/miso pins, frame, frame_valid,
//              frame_count, err_short, err_long, err_clr
// Stream byte i lands in frame[(FRAME_BYTES-1-i)*8 +: 8]. MISO returns the
// status byte followed by the received stream delayed by one byte.
module spi_frame_rx
    import spi_frame_rx_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = SYNTH_FRAME_BYTES,
    parameter int unsigned LSB_FIRST   = 1,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    spi_frame_rx_if.slave   bus
);
    localparam int unsigned FW          = FRAME_BYTES * 8;
    localparam int unsigned BCW         = $clog2(FRAME_BYTES + 1);
    localparam bit          SAMPLE_RISE = (CPOL == CPHA);

    spi_state_e             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             tx_q, tx_d;
    logic [FW-1:0]          shadow_q, shadow_d;
    logic [FW-1:0]          frame_q, frame_d;
    logic                   frame_valid_q, frame_valid_d;
    logic [7:0]             frame_count_q, frame_count_d;
    logic                   err_short_q, err_short_d;
    logic                   err_long_q, err_long_d;
    logic                   miso_q, miso_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    logic sclk_rise_c, sclk_fall_c, csel_rise_c, csel_fall_c;
    logic sample_c, shift_c, mosi_s, byte_full_c;
    logic [7:0] byte_c, status_c;
    logic [2:0] tx_idx_c;

    spi_frame_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'(CPOL))) u_sclk_sync (
        .clk(clk), .rst(rst), .d(bus.sclk), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );

    spi_frame_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_csel_sync (
        .clk(clk), .rst(rst), .d(bus.csel), .rise_c(csel_rise_c), .fall_c(csel_fall_c)
    );

    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sample_c    = SAMPLE_RISE ? sclk_rise_c : sclk_fall_c;
    assign shift_c     = SAMPLE_RISE ? sclk_fall_c : sclk_rise_c;
    assign byte_full_c = (byte_cnt_q == BCW'(FRAME_BYTES));
    assign byte_c      = (LSB_FIRST != 0) ? {mosi_s, shift_q[7:1]} : {shift_q[6:0], mosi_s};
    assign tx_idx_c    = (LSB_FIRST != 0) ? bit_cnt_q : 3'd7 - bit_cnt_q;
    assign status_c    = status_byte(err_long_q, err_short_q, frame_count_q[5:0]);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state; a csel rise outranks a sample edge in the same clk.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (csel_fall_c) state_d = RECV;
            RECV: begin
                if (csel_rise_c)                  state_d = IDLE;
                else if (sample_c && byte_full_c) state_d = OVERRUN;
            end
            OVERRUN: if (csel_rise_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath / outputs.
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        shift_d       = shift_q;
        tx_d          = tx_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        frame_count_d = frame_count_q;
        err_short_d   = bus.err_clr ? 1'b0 : err_short_q;
        err_long_d    = bus.err_clr ? 1'b0 : err_long_q;
        miso_d        = miso_q;

        case (state_q)
            IDLE: begin
                if (csel_fall_c) begin
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = '0;
                    shift_d    = 8'd0;
                    tx_d       = status_c;
                    // In CPHA=0 the host samples before any shift edge.
                    if (CPHA == 0) miso_d = status_c[(LSB_FIRST != 0) ? 3'd0 : 3'd7];
                end
            end
            RECV: begin
                if (csel_rise_c) begin
                    if (byte_full_c && bit_cnt_q == 3'd0) begin
                        frame_d       = shadow_q;
                        frame_valid_d = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
                    end else begin
                        err_short_d = 1'b1;
                    end
                end else begin
                    if (sample_c) begin
                        if (byte_full_c) begin
                            err_long_d = 1'b1;
                        end else begin
                            shift_d   = byte_c;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
                                    if (byte_cnt_q == BCW'(i))
                                        shadow_d[(FRAME_BYTES-1-i)*8 +: 8] = byte_c;
                                end
                                byte_cnt_d = byte_cnt_q + BCW'(1);
                                tx_d       = byte_c;
                            end
                        end
                    end
                    if (shift_c) miso_d = tx_q[tx_idx_c];
                end
            end
            OVERRUN: begin
                if (!csel_rise_c && shift_c) miso_d = tx_q[tx_idx_c];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_sync_q   <= '0;
            bit_cnt_q     <= 3'd0;
            byte_cnt_q    <= '0;
            shift_q       <= 8'd0;
            tx_q          <= 8'd0;
            shadow_q      <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_count_q <= 8'd0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            miso_q        <= 1'b0;
        end else begin
            mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            shift_q       <= shift_d;
            tx_q          <= tx_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            miso_q        <= miso_d;
        end
    end

    assign bus.miso        = miso_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_count = frame_count_q;
    assign bus.err_short   = err_short_q;
    assign bus.err_long    = err_long_q;
endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: dut0 = mode 0 LSB-first, dut1 = mode 3 MSB-first,
// both with 4-byte frames and sclk = clk/48.
module tb_spi_frame_rx;
    localparam int HALF = 240;
    localparam int FB   = 4;

    typedef struct {
        int          sel;
        int          nbits;
        logic        clr;
        logic [63:0] tx;
        int          miso_n;
        logic [63:0] exp_miso;
        logic [31:0] exp_frame;
        logic [7:0]  exp_cnt;
        logic        exp_short;
        logic        exp_long;
        int          exp_fv;
    } vec_t;

    logic clk = 1'b0;
    logic rst0, rst1;
    logic sclk_v[2], mosi_v[2], csel_v[2], clr_v[2];
    int   total, bad;
    int   fv0, fv1;
    logic [63:0] rx_data;
    vec_t vecs[10];

    always #5 clk = ~clk;

    spi_frame_rx_if #(.FRAME_BYTES(FB)) bus0 ();
    spi_frame_rx_if #(.FRAME_BYTES(FB)) bus1 ();

    assign bus0.sclk = sclk_v[0];
    assign bus0.mosi = mosi_v[0];
    assign bus0.csel = csel_v[0];
    assign bus0.err_clr = clr_v[0];
    assign bus1.sclk = sclk_v[1];
    assign bus1.mosi = mosi_v[1];
    assign bus1.csel = csel_v[1];
    assign bus1.err_clr = clr_v[1];

    spi_frame_rx #(.FRAME_BYTES(FB), .LSB_FIRST(1), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0));
    spi_frame_rx #(.FRAME_BYTES(FB), .LSB_FIRST(0), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1));

    initial begin
        fv0 = 0;
        fv1 = 0;
    end
    always @(posedge clk) if (bus0.frame_valid === 1'b1) fv0 = fv0 + 1;
    always @(posedge clk) if (bus1.frame_valid === 1'b1) fv1 = fv1 + 1;

    function automatic logic miso_of(input int sel);
        return (sel == 0) ? bus0.miso : bus1.miso;
    endfunction

    function automatic int fv_of(input int sel);
        return (sel == 0) ? fv0 : fv1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cs_low(input int sel);
        csel_v[sel] = 1'b0;
        #HALF;
    endtask

    task automatic cs_high(input int sel);
        #HALF;
        csel_v[sel] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    // Clock nbits of tx (stream byte i at tx[63-8i -: 8]); MISO lands in rx_data.
    task automatic xfer(input int sel, input int nbits, input logic [63:0] tx);
        logic cpol;
        int   bi, bpos;
        cpol    = (sel == 1);
        rx_data = '0;
        for (int b = 0; b < nbits; b++) begin
            bi   = b % 8;
            bpos = (7 - b / 8) * 8 + ((sel == 0) ? bi : 7 - bi);
            if (sel == 0) begin
                mosi_v[sel] = tx[bpos];
                #HALF;
                rx_data[bpos] = miso_of(sel);
                sclk_v[sel] = ~cpol;
                #HALF;
                sclk_v[sel] = cpol;
            end else begin
                sclk_v[sel] = ~cpol;
                mosi_v[sel] = tx[bpos];
                #HALF;
                rx_data[bpos] = miso_of(sel);
                sclk_v[sel] = cpol;
                #HALF;
            end
        end
    endtask

    task automatic pulse_clr(input int sel);
        @(posedge clk);
        #1 clr_v[sel] = 1'b1;
        @(posedge clk);
        #1 clr_v[sel] = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_outputs(input string tag, input int sel, input logic [31:0] fr,
                               input logic [7:0] cnt, input logic sh, input logic lg);
        if (sel == 0) begin
            chk({tag, "_frame"}, 64'(bus0.frame), 64'(fr));
            chk({tag, "_count"}, 64'(bus0.frame_count), 64'(cnt));
            chk({tag, "_short"}, 64'(bus0.err_short), 64'(sh));
            chk({tag, "_long"},  64'(bus0.err_long), 64'(lg));
        end else begin
            chk({tag, "_frame"}, 64'(bus1.frame), 64'(fr));
            chk({tag, "_count"}, 64'(bus1.frame_count), 64'(cnt));
            chk({tag, "_short"}, 64'(bus1.err_short), 64'(sh));
            chk({tag, "_long"},  64'(bus1.err_long), 64'(lg));
        end
    endtask

    initial begin
        vec_t v;
        int   fvb;
        total = 0;
        bad   = 0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        sclk_v[0] = 1'b0; sclk_v[1] = 1'b1;
        mosi_v[0] = 1'b0; mosi_v[1] = 1'b0;
        csel_v[0] = 1'b1; csel_v[1] = 1'b1;
        clr_v[0]  = 1'b0; clr_v[1]  = 1'b0;

        //        sel nbits clr tx                     n  exp_miso               frame         cnt  sh   lg  fv
        vecs[0] = '{0, 32, 1'b0, 64'hDEADBEEF_00000000, 4, 64'h00DEADBE_00000000, 32'hDEADBEEF, 8'd1, 1'b0, 1'b0, 1};
        vecs[1] = '{0, 32, 1'b0, 64'h01020304_00000000, 4, 64'h01010203_00000000, 32'h01020304, 8'd2, 1'b0, 1'b0, 1};
        vecs[2] = '{0, 24, 1'b0, 64'h11223300_00000000, 3, 64'h02112200_00000000, 32'h01020304, 8'd2, 1'b1, 1'b0, 0};
        vecs[3] = '{0,  0, 1'b1, 64'h0,                 0, 64'h0,                 32'h01020304, 8'd2, 1'b0, 1'b0, 0};
        vecs[4] = '{0, 40, 1'b0, 64'hAABBCCDD_EE000000, 4, 64'h02AABBCC_00000000, 32'h01020304, 8'd2, 1'b0, 1'b1, 0};
        vecs[5] = '{0, 32, 1'b0, 64'h12345678_00000000, 4, 64'h82123456_00000000, 32'h12345678, 8'd3, 1'b0, 1'b1, 1};
        vecs[6] = '{0,  0, 1'b1, 64'h0,                 0, 64'h0,                 32'h12345678, 8'd3, 1'b0, 1'b0, 0};
        vecs[7] = '{0, 20, 1'b0, 64'h9ABC5000_00000000, 2, 64'h039A0000_00000000, 32'h12345678, 8'd3, 1'b1, 1'b0, 0};
        vecs[8] = '{0,  0, 1'b1, 64'h0,                 0, 64'h0,                 32'h12345678, 8'd3, 1'b0, 1'b0, 0};
        vecs[9] = '{1, 32, 1'b0, 64'h80000001_00000000, 4, 64'h00800000_00000000, 32'h80000001, 8'd1, 1'b0, 1'b0, 1};

        repeat (5) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk_outputs("reset0", 0, 32'h0, 8'd0, 1'b0, 1'b0);
        chk("reset0_miso", 64'(bus0.miso), 64'(1'b0));
        chk("reset0_fv", 64'(bus0.frame_valid), 64'(1'b0));
        chk_outputs("reset1", 1, 32'h0, 8'd0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            if (v.clr) pulse_clr(v.sel);
            fvb = fv_of(v.sel);
            if (v.nbits > 0) begin
                cs_low(v.sel);
                xfer(v.sel, v.nbits, v.tx);
                cs_high(v.sel);
            end else begin
                repeat (4) @(negedge clk);
            end
            chk_outputs($sformatf("v%0d", i), v.sel, v.exp_frame, v.exp_cnt, v.exp_short, v.exp_long);
            chk($sformatf("v%0d_fv_pulses", i), 64'(fv_of(v.sel) - fvb), 64'(v.exp_fv));
            for (int k = 0; k < v.miso_n; k++)
                chk($sformatf("v%0d_miso_byte%0d", i, k),
                    64'(rx_data[63-8*k -: 8]), 64'(v.exp_miso[63-8*k -: 8]));
        end

        // Reset in the middle of the second byte.
        cs_low(0);
        xfer(0, 13, 64'hDEADBEEF_00000000);
        rst0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_outputs("midrst", 0, 32'h0, 8'd0, 1'b0, 1'b0);
        chk("midrst_miso", 64'(bus0.miso), 64'(1'b0));
        chk("midrst_fv", 64'(bus0.frame_valid), 64'(1'b0));

        // Released with csel still low: this byte must be ignored entirely.
        rst0 = 1'b0;
        repeat (5) @(posedge clk);
        fvb = fv0;
        xfer(0, 8, 64'hFF000000_00000000);
        cs_high(0);
        chk_outputs("postrst_idle", 0, 32'h0, 8'd0, 1'b0, 1'b0);
        chk("postrst_idle_fv", 64'(fv0 - fvb), 64'd0);

        fvb = fv0;
        cs_low(0);
        xfer(0, 32, 64'hDEADBEEF_00000000);
        cs_high(0);
        chk_outputs("postrst_frame", 0, 32'hDEADBEEF, 8'd1, 1'b0, 1'b0);
        chk("postrst_frame_fv", 64'(fv0 - fvb), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
- Parametrised SPI slave that receives one fixed-length configuration frame per chip-select assertion and commits it atomically to a wide register.
- The committed register is sized to hold a packed synth_t image; the top level casts it to synth_t.
- Sits between the board SPI pins (ck_mosi/ck_sck/ck_ss/ck_miso) and the synth core.
- Generalises the existing byte-serial load path with configurable frame length, SPI mode, bit order, length checking and a MISO status/echo channel.

Parameters:
- FRAME_BYTES, 64: bytes per frame. The top level sets this to $bits(synth_t)/8.
- LSB_FIRST, 1: 1 = first bit of each byte lands in bit 0; 0 = first bit lands in bit 7.
- CPOL, 0: idle level of sclk.
- CPHA, 0: 0 = sample on the leading edge and shift on the trailing edge; 1 = the reverse.
- SYNC_STAGES, 2: synchroniser depth on sclk, mosi and csel (minimum 2).

Ports:
- clk  in  1  system clock. Must be at least 8x sclk.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock (asynchronous to clk).
- mosi  in  1  SPI data in.
- csel  in  1  chip select, active low.
- miso  out  1  SPI data out.
- frame  out  FRAME_BYTES*8  last committed frame. Stream byte i maps to frame[(FRAME_BYTES-1-i)*8 +: 8].
- frame_valid  out  1  one-clk pulse on each successful commit.
- frame_count  out  8  number of commits, wraps 255->0.
- err_short  out  1  sticky flag: frame ended early (fewer than FRAME_BYTES whole bytes, or a partial byte).
- err_long  out  1  sticky flag: more than FRAME_BYTES bytes were clocked.
- err_clr  in  1  clears both sticky error flags.

Behaviour:
- Reset values:
  - frame = 0, frame_valid = 0, frame_count = 0, err_short = 0, err_long = 0, miso = 0.
  - Shadow buffer = 0, bit counter = 0, byte counter = 0, FSM = IDLE.
  - Synchroniser flops reset to the idle levels: sclk = CPOL, csel = 1, mosi = 0.
- Synchronisation and edge detection:
  - sclk, mosi and csel each pass through SYNC_STAGES flops.
  - Edges are detected from the last synchroniser stage against one further delay flop.
  - A pin edge is therefore acted on SYNC_STAGES+1 clk cycles after it occurs.
  - The sample edge is chosen from CPOL and CPHA: rising when CPOL==CPHA, falling otherwise.
- FSM states: IDLE, RECV, OVERRUN.
- IDLE:
  - csel falling edge -> RECV.
  - On entry: clear bit counter, byte counter and the shift register; load the tx shift register with the status byte {err_long, err_short, frame_count[5:0]}.
- RECV:
  - Each sample edge shifts mosi into the shift register in the order set by LSB_FIRST and increments the bit counter (3 bits).
  - When the bit counter wraps 7->0, write the completed byte into shadow byte slot byte_count and increment byte_count.
  - The written byte is also loaded as the next tx byte (echo), so the host sees the status byte and then the stream delayed by one byte.
  - When byte_count reaches FRAME_BYTES and another sample edge arrives -> OVERRUN.
- OVERRUN:
  - Sample edges are ignored and the shadow buffer is frozen.
  - err_long is set on entry.
- Shift edge:
  - miso changes only on the shift edge.
  - For CPHA=0, bit 0 of the tx byte is driven immediately on the csel falling edge.
  - Tx order follows LSB_FIRST.
- csel rising edge (from RECV or OVERRUN) -> IDLE:
  - If byte_count == FRAME_BYTES, bit counter == 0 and state was RECV: frame <= shadow on that clk, frame_valid pulses for 1 clk, frame_count increments.
  - If the frame is short or has a partial byte: set err_short. frame is unchanged and the partial byte is discarded.
  - If the state was OVERRUN: no commit (err_long is already set).
- Error flags:
  - err_clr clears the flags in the cycle it is high.
  - If a set event and err_clr occur in the same cycle, the set wins.
- Shadow buffer contents are not cleared between frames. Only the bytes written in the current transaction are meaningful; the commit rule guarantees all FRAME_BYTES were written.
- Reset during a transaction aborts it immediately. After reset release with csel still low, the FSM stays in IDLE until the next csel falling edge.
- A sample edge and a csel rising edge detected in the same clk: the csel edge takes priority and the sample is dropped.
- frame is stable at all times except the single commit cycle. There is no read-side handshake.

Decomposition:
- The existing protocol package gains a typedef spi_state_e {IDLE, RECV, OVERRUN} and a function status_byte(err_long, err_short, count).
- FRAME_BYTES for the top level is derived from $bits(synth_t)/8 in the package.
- One sub-module: spi_sync_edge, a SYNC_STAGES synchroniser plus rise/fall strobes, instantiated once each for sclk and csel. mosi uses its synchroniser only.

Test Plan:
- Nominal frame (FRAME_BYTES=4, LSB_FIRST=1, mode 0, sclk = clk/48), send 0xDE 0xAD 0xBE 0xEF -> frame = 32'hDEADBEEF one commit cycle after the csel rising edge is detected; frame_valid is high for exactly 1 clk; frame_count = 1; both error flags = 0.
- Echo/status: second frame 0x01 0x02 0x03 0x04 -> miso bytes read by the host = 0x01 (status: count=1), 0x01, 0x02, 0x03; frame = 32'h01020304; frame_count = 2.
- Short frame: 3 bytes then csel high -> err_short = 1, frame keeps its old value, no frame_valid. Then err_clr -> err_short = 0.
- Long frame: 5 bytes -> err_long = 1, no commit. The next good 4-byte frame commits normally and err_long stays 1 until cleared.
- Mode/order sweep: CPOL=1, CPHA=1, LSB_FIRST=0, send 0x80 0x00 0x00 0x01 -> frame = 32'h80000001.
- Reset mid-byte: assert rst after 13 bits -> all outputs 0 on the next clk. Re-send the full frame after release -> correct commit, frame_count = 1.
